// File: rtl/core_mac_pkg.sv
// Shared constants and helpers for the MAC core.
// - sum_w:    width of one beat's exact dot-product sum
// - tree_lat: register stages inside the pipelined adder tree
// - mac_lat:  total input-to-result latency in clock edges
// - sat_hi / sat_lo: clamp limits for a given width and signedness
package core_mac_pkg;

    typedef enum logic {
        ACC_IDLE,
        ACC_OPEN
    } acc_state_e;

    function automatic int unsigned sum_w(input int unsigned iw, input int unsigned lanes);
        return 2 * iw + $clog2(lanes);
    endfunction

    function automatic int unsigned tree_lat(input int unsigned lanes, input int unsigned pipe_every);
        return ($clog2(lanes) + pipe_every - 1) / pipe_every;
    endfunction

    // Operand register + product register + tree registers + accumulate/output register.
    function automatic int unsigned mac_lat(input int unsigned lanes, input int unsigned pipe_every);
        return 2 + tree_lat(lanes, pipe_every) + 1;
    endfunction

    // Largest representable value; callers truncate to their width (w <= 64).
    function automatic logic [63:0] sat_hi(input int unsigned w, input logic is_signed);
        return is_signed ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
    endfunction

    // Smallest representable value; callers truncate to their width (w <= 64).
    function automatic logic [63:0] sat_lo(input int unsigned w, input logic is_signed);
        return is_signed ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree with sideband carry.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears valid bits only)
//   in_data               N lanes of IN_W bits, lane i at [i*IN_W +: IN_W]
//   in_valid/first/last   beat sidebands, delayed alongside the data
//   in_signed             sign-extends lanes when set, zero-extends otherwise
//   out_data              OUT_W-bit sum (OUT_W = IN_W + clog2(N))
//   out_valid/first/last/signed  delayed sidebands
// A register follows every PIPE_EVERY-th level and always the final level.
module adder_tree_pipe
    import core_mac_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 20,
    parameter int unsigned PIPE_EVERY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*IN_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic                in_last,
    input  logic                in_signed,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic                out_signed
);

    localparam int unsigned LEVELS = $clog2(N);

    // Extend every lane once to the full output width so all additions are exact.
    logic [N*OUT_W-1:0] ext_bus;

    always_comb begin
        ext_bus = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ext_bus[i*OUT_W +: OUT_W] = {{(OUT_W - IN_W){in_signed & in_data[i*IN_W + IN_W - 1]}},
                                         in_data[i*IN_W +: IN_W]};
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned CNT    = N >> (l + 1);
        localparam bit          IS_REG = (((l + 1) % PIPE_EVERY) == 0) || ((l + 1) == LEVELS);

        logic [2*CNT*OUT_W-1:0] din;
        logic                   vin, fin, lin, sin;
        logic [CNT*OUT_W-1:0]   sum_d;
        logic [CNT*OUT_W-1:0]   dout;
        logic                   vout, fout, lout, sout;

        if (l == 0) begin : g_src
            assign din = ext_bus;
            assign vin = in_valid;
            assign fin = in_first;
            assign lin = in_last;
            assign sin = in_signed;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
            assign vin = g_lvl[l-1].vout;
            assign fin = g_lvl[l-1].fout;
            assign lin = g_lvl[l-1].lout;
            assign sin = g_lvl[l-1].sout;
        end

        always_comb begin
            sum_d = '0;
            for (int unsigned j = 0; j < CNT; j++) begin
                sum_d[j*OUT_W +: OUT_W] = din[(2*j)*OUT_W +: OUT_W] + din[(2*j+1)*OUT_W +: OUT_W];
            end
        end

        if (IS_REG) begin : g_reg
            logic [CNT*OUT_W-1:0] data_q;
            logic                 valid_q, first_q, last_q, signed_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= vin;
                end
                data_q   <= sum_d;
                first_q  <= fin;
                last_q   <= lin;
                signed_q <= sin;
            end

            assign dout = data_q;
            assign vout = valid_q;
            assign fout = first_q;
            assign lout = last_q;
            assign sout = signed_q;
        end else begin : g_comb
            assign dout = sum_d;
            assign vout = vin;
            assign fout = fin;
            assign lout = lin;
            assign sout = sin;
        end
    end

    assign out_data   = g_lvl[LEVELS-1].dout;
    assign out_valid  = g_lvl[LEVELS-1].vout;
    assign out_first  = g_lvl[LEVELS-1].fout;
    assign out_last   = g_lvl[LEVELS-1].lout;
    assign out_signed = g_lvl[LEVELS-1].sout;

endmodule

// File: rtl/core_mac_acc.sv
// Multi-lane MAC with pipelined adder tree and multi-beat group accumulator.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   idataA, idataB    lane operands, lane i at [i*IDATA_WIDTH +: IDATA_WIDTH]
//   idata_valid       beat valid (no backpressure)
//   idata_first/last  group framing, qualified by idata_valid
//   idata_signed      operand signedness, taken from the group's first beat
//   odata             group result, held between pulses
//   odata_valid       one-cycle pulse per closed group
//   odata_sat         group saturated at least once
//   odata_beats       beats in the group, saturating at all-ones
module core_mac_acc
    import core_mac_pkg::*;
#(
    parameter int unsigned MAC_MULT_NUM = 16,
    parameter int unsigned IDATA_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned PIPE_EVERY   = 2,
    parameter bit          SAT_EN       = 1'b1,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IDATA_WIDTH*MAC_MULT_NUM-1:0] idataA,
    input  logic [IDATA_WIDTH*MAC_MULT_NUM-1:0] idataB,
    input  logic                                idata_valid,
    input  logic                                idata_first,
    input  logic                                idata_last,
    input  logic                                idata_signed,
    output logic [ACC_WIDTH-1:0]                odata,
    output logic                                odata_valid,
    output logic                                odata_sat,
    output logic [CNT_WIDTH-1:0]                odata_beats
);

    localparam int unsigned IW     = IDATA_WIDTH;
    localparam int unsigned NL     = MAC_MULT_NUM;
    localparam int unsigned PROD_W = 2 * IW;
    localparam int unsigned SUM_W  = sum_w(IW, NL);

    localparam logic [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'(sat_hi(ACC_WIDTH, 1'b1));
    localparam logic [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(sat_lo(ACC_WIDTH, 1'b1));
    localparam logic [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'(sat_hi(ACC_WIDTH, 1'b0));

    // ---------------- input mode tracking + operand register ----------------
    // Mode is resolved at the input so each beat carries its group's mode
    // down the pipe; an orphan beat (no group open) opens an implicit group.
    logic in_open_q, in_open_d;
    logic mode_q, mode_d;
    logic start_in, beat_signed;

    always_comb begin
        start_in    = idata_valid & (idata_first | ~in_open_q);
        beat_signed = start_in ? idata_signed : mode_q;
        in_open_d   = in_open_q;
        mode_d      = mode_q;
        if (idata_valid) begin
            in_open_d = ~idata_last;
            if (start_in) begin
                mode_d = idata_signed;
            end
        end
    end

    logic [NL*IW-1:0] a_q, b_q;
    logic             op_valid_q, op_first_q, op_last_q, op_signed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_open_q  <= 1'b0;
            mode_q     <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            in_open_q  <= in_open_d;
            mode_q     <= mode_d;
            op_valid_q <= idata_valid;
        end
        a_q         <= idataA;
        b_q         <= idataB;
        op_first_q  <= idata_first;
        op_last_q   <= idata_last;
        op_signed_q <= beat_signed;
    end

    // ---------------- lane multiply + product register ----------------
    // Operands are extended to 2*IW per mode; the low 2*IW bits of the
    // product are then correct for both signed and unsigned interpretation.
    logic [NL*PROD_W-1:0] prod_d, prod_q;
    logic                 prod_valid_q, prod_first_q, prod_last_q, prod_signed_q;

    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            prod_d[i*PROD_W +: PROD_W] =
                {{IW{op_signed_q & a_q[i*IW + IW - 1]}}, a_q[i*IW +: IW]} *
                {{IW{op_signed_q & b_q[i*IW + IW - 1]}}, b_q[i*IW +: IW]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_valid_q <= 1'b0;
        end else begin
            prod_valid_q <= op_valid_q;
        end
        prod_q        <= prod_d;
        prod_first_q  <= op_first_q;
        prod_last_q   <= op_last_q;
        prod_signed_q <= op_signed_q;
    end

    // ---------------- adder tree ----------------
    logic [SUM_W-1:0] t_sum;
    logic             t_valid, t_first, t_last, t_signed;

    adder_tree_pipe #(
        .N          (NL),
        .IN_W       (PROD_W),
        .OUT_W      (SUM_W),
        .PIPE_EVERY (PIPE_EVERY)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .in_data    (prod_q),
        .in_valid   (prod_valid_q),
        .in_first   (prod_first_q),
        .in_last    (prod_last_q),
        .in_signed  (prod_signed_q),
        .out_data   (t_sum),
        .out_valid  (t_valid),
        .out_first  (t_first),
        .out_last   (t_last),
        .out_signed (t_signed)
    );

    // ---------------- accumulator FSM + output register ----------------
    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d;
    logic [ACC_WIDTH-1:0] odata_q, odata_d;
    logic                 ovalid_q, ovalid_d;
    logic                 osat_q, osat_d;
    logic [CNT_WIDTH-1:0] obeats_q, obeats_d;

    logic [ACC_WIDTH:0]   sum_ext, acc_ext, add;
    logic                 ovf;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        beats_d  = beats_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        osat_d   = osat_q;
        obeats_d = obeats_q;

        sum_ext = {{(ACC_WIDTH + 1 - SUM_W){t_signed & t_sum[SUM_W-1]}}, t_sum};
        acc_ext = {t_signed & acc_q[ACC_WIDTH-1], acc_q};
        add     = acc_ext + sum_ext;
        // Signed: the two top bits disagree. Unsigned: carry out.
        ovf     = t_signed ? (add[ACC_WIDTH] ^ add[ACC_WIDTH-1]) : add[ACC_WIDTH];

        if (t_valid) begin
            if (t_first || (state_q == ACC_IDLE)) begin
                acc_d   = sum_ext[ACC_WIDTH-1:0];
                sat_d   = 1'b0;
                beats_d = CNT_WIDTH'(1);
            end else begin
                beats_d = (&beats_q) ? beats_q : beats_q + CNT_WIDTH'(1);
                if (ovf && SAT_EN) begin
                    sat_d = 1'b1;
                    if (!t_signed) begin
                        acc_d = U_MAX;
                    end else if (add[ACC_WIDTH]) begin
                        acc_d = S_MIN;
                    end else begin
                        acc_d = S_MAX;
                    end
                end else begin
                    acc_d = add[ACC_WIDTH-1:0];
                end
            end

            if (t_last) begin
                state_d  = ACC_IDLE;
                ovalid_d = 1'b1;
                odata_d  = acc_d;
                osat_d   = sat_d;
                obeats_d = beats_d;
            end else begin
                state_d = ACC_OPEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACC_IDLE;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            beats_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            osat_q   <= 1'b0;
            obeats_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            beats_q  <= beats_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            osat_q   <= osat_d;
            obeats_q <= obeats_d;
        end
    end

    assign odata       = odata_q;
    assign odata_valid = ovalid_q;
    assign odata_sat   = osat_q;
    assign odata_beats = obeats_q;

endmodule

// File: tb/tb_core_mac_acc.sv
// Directed bench for core_mac_acc: one default instance plus two
// ACC_WIDTH=20 instances (saturating and wrapping) sharing the same stimulus.
module tb_core_mac_acc;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] idataA, idataB;
    logic         idata_valid, idata_first, idata_last, idata_signed;

    logic [31:0]  o0;
    logic         v0, s0;
    logic [7:0]   b0;
    logic [19:0]  o1, o2;
    logic         v1, s1, v2, s2;
    logic [7:0]   b1, b2;

    int n_vec  = 0;
    int n_miss = 0;
    int vcnt0  = 0;
    int base;

    always #5 clk = ~clk;

    always @(negedge clk) if (v0) vcnt0++;

    core_mac_acc u_dut0 (
        .clk (clk), .rst (rst), .idataA (idataA), .idataB (idataB),
        .idata_valid (idata_valid), .idata_first (idata_first), .idata_last (idata_last),
        .idata_signed (idata_signed),
        .odata (o0), .odata_valid (v0), .odata_sat (s0), .odata_beats (b0)
    );

    core_mac_acc #(.ACC_WIDTH (20), .SAT_EN (1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .idataA (idataA), .idataB (idataB),
        .idata_valid (idata_valid), .idata_first (idata_first), .idata_last (idata_last),
        .idata_signed (idata_signed),
        .odata (o1), .odata_valid (v1), .odata_sat (s1), .odata_beats (b1)
    );

    core_mac_acc #(.ACC_WIDTH (20), .SAT_EN (1'b0)) u_dut2 (
        .clk (clk), .rst (rst), .idataA (idataA), .idataB (idataB),
        .idata_valid (idata_valid), .idata_first (idata_first), .idata_last (idata_last),
        .idata_signed (idata_signed),
        .odata (o2), .odata_valid (v2), .odata_sat (s2), .odata_beats (b2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for one cycle; returns #1 after the edge that samples it.
    task automatic drive_vec(input logic [127:0] a, input logic [127:0] b,
                             input logic f, input logic l, input logic s);
        idataA       = a;
        idataB       = b;
        idata_first  = f;
        idata_last   = l;
        idata_signed = s;
        idata_valid  = 1'b1;
        tick();
        idata_valid  = 1'b0;
        idata_first  = 1'b0;
        idata_last   = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic f, input logic l, input logic s);
        drive_vec({16{a}}, {16{b}}, f, l, s);
    endtask

    initial begin
        logic [127:0] va, vb;

        rst = 1'b1;
        idataA = '0; idataB = '0;
        idata_valid = 1'b0; idata_first = 1'b0; idata_last = 1'b0; idata_signed = 1'b0;
        wait_n(2);
        rst = 1'b0;

        chk("rst_odata",  64'(o0), 64'h0);
        chk("rst_valid",  64'(v0), 64'h0);
        chk("rst_sat",    64'(s0), 64'h0);
        chk("rst_beats",  64'(b0), 64'h0);
        chk("rst_odata1", 64'(o1), 64'h0);

        // Single beat signed: 16 * (-1 * 2) = -32; result 5 edges after presentation
        drive(8'hFF, 8'h02, 1'b1, 1'b1, 1'b1);
        wait_n(3);
        chk("t1_early", 64'(v0), 64'h0);
        tick();
        chk("t1_odata", 64'(o0), 64'hFFFF_FFE0);
        chk("t1_valid", 64'(v0), 64'h1);
        chk("t1_beats", 64'(b0), 64'h1);
        chk("t1_sat",   64'(s0), 64'h0);
        tick();
        chk("t1_pulse", 64'(v0), 64'h0);

        // Same, unsigned: 16 * 255 * 2 = 8160
        drive(8'hFF, 8'h02, 1'b1, 1'b1, 1'b0);
        wait_n(4);
        chk("t2_odata", 64'(o0), 64'd8160);
        chk("t2_valid", 64'(v0), 64'h1);
        tick();
        base = vcnt0;

        // Three beats with a bubble: 3 * 16 = 48, one pulse
        drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
        drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
        wait_n(3);
        chk("t3_hold",  64'(o0), 64'd8160);
        tick();
        chk("t3_odata", 64'(o0), 64'd48);
        chk("t3_valid", 64'(v0), 64'h1);
        chk("t3_beats", 64'(b0), 64'd3);
        tick();
        chk("t3_pulses", 64'(vcnt0 - base), 64'd1);

        // Back-to-back single-beat groups: 48 then 64
        drive(8'h01, 8'h03, 1'b1, 1'b1, 1'b1);
        drive(8'h02, 8'h02, 1'b1, 1'b1, 1'b1);
        wait_n(3);
        chk("t4_odata_a", 64'(o0), 64'd48);
        chk("t4_valid_a", 64'(v0), 64'h1);
        tick();
        chk("t4_odata_b", 64'(o0), 64'd64);
        chk("t4_valid_b", 64'(v0), 64'h1);
        tick();
        chk("t4_pulse",   64'(v0), 64'h0);

        // Signed positive overflow at ACC_WIDTH=20: 2 * 262144 = 524288
        drive(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
        drive(8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
        wait_n(4);
        chk("t5_sat_odata",  64'(o1), 64'h7FFFF);
        chk("t5_sat_flag",   64'(s1), 64'h1);
        chk("t5_sat_valid",  64'(v1), 64'h1);
        chk("t5_wrap_odata", 64'(o2), 64'h80000);
        chk("t5_wrap_flag",  64'(s2), 64'h0);
        chk("t5_w32_odata",  64'(o0), 64'd524288);
        chk("t5_w32_beats",  64'(b0), 64'd2);

        // Unsigned overflow then a zero beat: clamp and sticky sat
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_n(4);
        chk("t6_sat_odata",  64'(o1), 64'hFFFFF);
        chk("t6_sat_sticky", 64'(s1), 64'h1);
        chk("t6_sat_beats",  64'(b1), 64'd3);
        chk("t6_wrap_odata", 64'(o2), 64'd1032224);
        chk("t6_w32_odata",  64'(o0), 64'd2080800);
        chk("t6_w32_sat",    64'(s0), 64'h0);

        // Signed negative overflow: 3 * (-260096) = -780288
        drive(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);
        drive(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1);
        drive(8'h80, 8'h7F, 1'b0, 1'b1, 1'b1);
        wait_n(4);
        chk("t7_sat_odata",  64'(o1), 64'h80000);
        chk("t7_sat_flag",   64'(s1), 64'h1);
        chk("t7_wrap_odata", 64'(o2), 64'h41800);
        chk("t7_w32_odata",  64'(o0), 64'hFFF4_1800);

        // Mode is taken from the first beat only: -16 + -16 = -32
        drive(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        wait_n(4);
        chk("t8_mode_latch", 64'(o0), 64'hFFFF_FFE0);

        // Orphan beat without first opens an implicit group
        drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        wait_n(4);
        chk("t9_odata", 64'(o0), 64'd16);
        chk("t9_beats", 64'(b0), 64'd1);
        chk("t9_valid", 64'(v0), 64'h1);

        // Distinct lanes: sum i*(i+1), i=0..15 = 1360
        va = '0;
        vb = '0;
        for (int i = 0; i < 16; i++) begin
            va[i*8 +: 8] = 8'(i);
            vb[i*8 +: 8] = 8'(i + 1);
        end
        drive_vec(va, vb, 1'b1, 1'b1, 1'b0);
        wait_n(4);
        chk("t10_lanes", 64'(o0), 64'd1360);

        // 300-beat group: beat counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            drive(8'h00, 8'h00, (i == 0), (i == 299), 1'b0);
        end
        wait_n(4);
        chk("t11_beats", 64'(b0), 64'd255);
        chk("t11_odata", 64'(o0), 64'd0);
        chk("t11_valid", 64'(v0), 64'h1);
        tick();

        // Reset with a group in flight: no pulse, outputs cleared
        base = vcnt0;
        drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
        drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_n(8);
        chk("t12_no_pulse", 64'(vcnt0 - base), 64'd0);
        chk("t12_odata",    64'(o0), 64'd0);
        drive(8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
        wait_n(4);
        chk("t12_after_odata", 64'(o0), 64'd16);
        chk("t12_after_beats", 64'(b0), 64'd1);
        chk("t12_after_valid", 64'(v0), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/core_mac_acc.md
Name: core_mac_acc

Overview:
- Next-generation MAC core: N-lane multiply, configurable-pipelined adder tree, and a multi-beat accumulator for dot products longer than one beat (K-dimension tiling).
- Adds runtime signed/unsigned mode, group framing (first/last), saturating accumulation with a sticky flag, and a beat counter.
- Sits between the operand fetch logic and the output/requant stage of the core datapath.

Parameters:
- MAC_MULT_NUM, 16, lanes per beat; power of two, at least 2.
- IDATA_WIDTH, 8, operand width per lane.
- ACC_WIDTH, 32, accumulator/output width; must be at least SUM_W = 2*IDATA_WIDTH + clog2(MAC_MULT_NUM).
- PIPE_EVERY, 2, a register follows every PIPE_EVERY-th tree stage and the final stage.
- SAT_EN, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.
- CNT_WIDTH, 8, width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- idataA  in  IDATA_WIDTH*MAC_MULT_NUM  lane operands A; lane i occupies bits [i*IDATA_WIDTH +: IDATA_WIDTH].
- idataB  in  IDATA_WIDTH*MAC_MULT_NUM  lane operands B.
- idata_valid  in  1  beat valid; there is no backpressure.
- idata_first  in  1  beat opens a group; qualified by idata_valid.
- idata_last  in  1  beat closes a group; qualified by idata_valid.
- idata_signed  in  1  1 = two's-complement operands; sampled on the first beat only.
- odata  out  ACC_WIDTH  group result.
- odata_valid  out  1  one-cycle pulse per closed group.
- odata_sat  out  1  group saturated (sticky over the group).
- odata_beats  out  CNT_WIDTH  beats in the group; saturates at all-ones.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a clk edge:
  - odata, odata_valid, odata_sat and odata_beats are cleared to 0.
  - All pipeline valid bits, the accumulator, the group-open flag, the sticky sat flag and the beat counter are cleared.
  - Data registers need no reset; every use of them is gated by the corresponding valid bit.
- Latency:
  - TREE_LAT = ceil(clog2(MAC_MULT_NUM) / PIPE_EVERY).
  - LAT = 2 + TREE_LAT + 1, made up of the operand register, the product register, the tree registers and the accumulate/output register.
  - A last beat accepted at edge t produces odata_valid=1 at edge t+LAT.
  - Defaults: LAT = 5.
- Mode:
  - The signed flag is latched on the first beat and travels down the pipeline with that beat.
  - Later beats of the group use the latched value.
  - Lane products are signed or unsigned per the flag; tree and accumulator extension (sign or zero) follow the same flag.
- Accumulate stage, on a beat that reaches the accumulator:
  - If the beat is first, or no group is open: acc = sum, sat = 0, beats = 1. A beat without first while no group is open is treated as an implicit first.
  - Otherwise: acc = acc + sum and beats = beats + 1, saturating at all-ones.
  - The addition is computed in ACC_WIDTH+1 bits. On overflow with SAT_EN=1, clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) in signed mode, or to 2^ACC_WIDTH-1 in unsigned mode, and set sat. With SAT_EN=0, wrap and never set sat.
  - If the beat is last: odata, odata_sat and odata_beats take the post-update values, odata_valid pulses, and the group closes.
- Framing:
  - first=last=1 on the same beat is a single-beat group.
  - Bubbles (idata_valid=0) inside a group are allowed; the accumulator holds its value.
  - Back-to-back groups (last at t, first at t+1) are fully pipelined and produce results at t+LAT and t+1+LAT.
  - odata holds its last value between pulses.
- A reset during operation discards every in-flight beat and produces no result pulse for them.

Decomposition:
- Package core_mac_pkg:
  - Function for SUM_W.
  - Function for TREE_LAT / LAT.
  - Saturation limit constants as functions of width and mode.
- Sub-module adder_tree_pipe:
  - Adder tree with a signed/unsigned extension flag and PIPE_EVERY register insertion.
  - Carries valid, first, last and mode sidebands alongside the data with matching delay.
- Top-level holds the multiply stage, the accumulator FSM (states IDLE and OPEN) and the output register.

Test Plan (defaults unless stated; LAT=5):
- Single beat, signed: all A=0xFF (-1), B=2, first=last=1 -> odata=0xFFFFFFE0 (-32), beats=1, sat=0 at t+5.
- Same stimulus with idata_signed=0 -> odata=8160 (255*2*16).
- Three beats, A=1, B=1, with one idle cycle between beats 2 and 3 -> a single odata_valid pulse, odata=48, beats=3, 5 cycles after the last beat.
- Back-to-back groups: single beat A=1, B=3 at t, then single beat A=2, B=2 at t+1 -> odata=48 at t+5 and odata=64 at t+6; odata_valid high on both cycles.
- ACC_WIDTH=20, signed, two beats of A=-128, B=-128 (262144 each) -> odata=524287, sat=1. Same with SAT_EN=0 -> odata=0x80000 (-524288), sat=0.
- rst pulsed 2 cycles after the first beat of an open 3-beat group -> no odata_valid, odata=0; a subsequent single beat A=1, B=1 -> odata=16, beats=1.
